prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: memory word address the first loaded word is written to.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  load request; sampled high for at least one cycle.
REQ-005 rx_data  input  8  incoming byte from the serial receiver.
REQ-006 rx_valid  input  1  rx_data holds a valid byte.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
REQ-008 address  output  16  memory word address toward the memory controller.
REQ-009 data_out  output  32  write data toward the memory controller.
REQ-010 we  output  1  memory write strobe, one cycle per word.
REQ-011 cpu_hold  output  1  held high while loading; ORed into the CPU reset at top level.
REQ-012 busy / done / error  output  1 each  loading in progress / last load completed OK / last load failed.

Function
REQ-013 States: IDLE, CNT_HI, CNT_LO, BYTE, WRITE, CHK, DONE, ERROR.
REQ-014 start in IDLE, DONE or ERROR -> CNT_HI next cycle; sets cpu_hold=1 and busy=1; clears done and error, the word index and the checksum; start is ignored in every other state.
REQ-015 rx_ready=1 exactly in CNT_HI, CNT_LO, BYTE and CHK; 0 in all other states.
REQ-016 CNT_HI/CNT_LO: accepted bytes form the 16-bit word count N, high byte first.
REQ-017 N=0: CNT_LO -> CHK if checksum is enabled, else DONE; no writes are issued.
REQ-018 BYTE: four accepted bytes form one word, MSB first (first byte -> data_out[31:24]); the 4th byte -> WRITE.
REQ-019 WRITE lasts exactly one cycle: we=1, address=BASE_ADDR+index (mod 2^16, wraps 16'hFFFF->16'h0000), data_out=assembled word; index increments.
REQ-020 After WRITE: index<N -> BYTE; index==N -> CHK (checksum enabled) or DONE.
REQ-021 Stalls: rx_valid low holds the current state and partial word indefinitely; no timeout.
REQ-022 DONE: cpu_hold=0, busy=0, done=1; asserted the cycle after the final WRITE (or after the checksum byte).
REQ-023 ERROR: cpu_hold stays 1, busy=0, error=1, so the CPU never runs a corrupt image.
REQ-024 we=0 in every state except WRITE; address and data_out hold their last values outside WRITE.

Reset
REQ-025 reset (any time, including mid-word or mid-WRITE) forces IDLE immediately, without waiting for a clock edge.
REQ-026 During reset: we=0, rx_ready=0, cpu_hold=0, busy=0, done=0, error=0, address=0, data_out=0, index/count/checksum=0.
REQ-027 No partial word is written after reset releases; a new start is required.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: the 8-bit checksum is the sum mod 256 of all data bytes (count bytes excluded), and one extra byte is accepted in CHK; a match -> DONE, a mismatch -> ERROR.
REQ-029 LOADER_CHECKSUM_EN undefined: the CHK state, the checksum register and the ERROR entry path are absent; error is tied to 0.

Structure
REQ-030 Shared package scic_pkg holds the state enum, SCIC_ADDR_W=16, SCIC_DATA_W=32 and the checksum width constant.
REQ-031 Sub-module word_packer (a 4-byte shift register plus a 2-bit byte counter with a word_full flag) is instantiated once; the FSM, address generation and checksum stay in prog_loader.

Verification
REQ-032 start, then bytes 00 02 DE AD BE EF 01 02 03 04 -> we pulses at address 0000 (data DEADBEEF) and 0001 (data 01020304); done=1; cpu_hold falls.
REQ-033 BASE_ADDR=16'hFFFF, N=2 -> the writes land at FFFF then 0000.
REQ-034 N=0 -> no we pulse; done=1 one cycle after the count low byte (checksum build: after checksum byte 00).
REQ-035 rx_valid dropped for 10 cycles between the 2nd and 3rd bytes of a word -> same data_out; we occurs only after the 4th byte.
REQ-036 Reset asserted after 2 bytes of word 1 -> IDLE at once, we never rises; a subsequent start reloads cleanly.
REQ-037 With LOADER_CHECKSUM_EN, word 11223344 plus checksum AA (correct value is AA) -> done; checksum AB -> error=1, cpu_hold remains 1.

Source files
------------

// File: rtl/scic_pkg.sv
// Shared constants and FSM state encoding for the serial program loader.
package scic_pkg;

    localparam int unsigned SCIC_ADDR_W = 16;
    localparam int unsigned SCIC_DATA_W = 32;
    localparam int unsigned SCIC_CSUM_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StCntHi = 3'd1;
    localparam state_t StCntLo = 3'd2;
    localparam state_t StByte  = 3'd3;
    localparam state_t StWrite = 3'd4;
    localparam state_t StChk   = 3'd5;
    localparam state_t StDone  = 3'd6;
    localparam state_t StError = 3'd7;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream receive handshake plus memory write port of the program loader.
interface prog_loader_if;
    import scic_pkg::*;

    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [SCIC_ADDR_W-1:0] address;
    logic [SCIC_DATA_W-1:0] data_out;
    logic                   we;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, address, data_out, we
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, address, data_out, we
    );

endinterface

// File: rtl/word_packer.sv
// Four-byte MSB-first shift register; word_full marks the byte that completes a word.
module word_packer
    import scic_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [SCIC_DATA_W-1:0] word,
    output logic                   word_full
);

    logic [SCIC_DATA_W-1:0] shift_q;
    logic [1:0]             cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[SCIC_DATA_W-9:0], byte_in};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    assign word      = shift_q;
    assign word_full = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: count header, MSB-first words written from BASE_ADDR upward.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
    import scic_pkg::*;
#(
    parameter logic [SCIC_ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         error
);

    state_t                 state_q, state_d;
    logic [SCIC_ADDR_W-1:0] count_q, index_q, address_q;
    logic [SCIC_DATA_W-1:0] data_q, word;
    logic [SCIC_ADDR_W-1:0] index_inc, write_addr;
    logic                   accept, load, shift_en, word_full, in_write, chk_state;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t StFinish = StChk;
    logic [SCIC_CSUM_W-1:0] csum_q;
`else
    localparam state_t StFinish = StDone;
`endif

    assign accept     = bus.rx_valid && bus.rx_ready;
    assign shift_en   = accept && (state_q == StByte);
    assign index_inc  = index_q + 16'd1;
    assign write_addr = BASE_ADDR + index_q;
    assign in_write   = (state_q == StWrite);

`ifdef LOADER_CHECKSUM_EN
    assign load = start && (state_q inside {StIdle, StDone, StError});
`else
    assign load = start && (state_q inside {StIdle, StDone});
`endif

    word_packer u_word_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (load),
        .shift_en  (shift_en),
        .byte_in   (bus.rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StCntHi;
`ifdef LOADER_CHECKSUM_EN
            StError: if (start) state_d = StCntHi;
            StChk: if (accept) state_d = (bus.rx_data == csum_q) ? StDone : StError;
`endif
            StCntHi: if (accept) state_d = StCntLo;
            StCntLo: begin
                if (accept) begin
                    state_d = ({count_q[15:8], bus.rx_data} == 16'd0) ? StFinish : StByte;
                end
            end
            StByte:  if (word_full) state_d = StWrite;
            StWrite: state_d = (index_inc == count_q) ? StFinish : StByte;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            index_q   <= '0;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                count_q <= '0;
                index_q <= '0;
            end
            if (accept && (state_q == StCntHi)) count_q[15:8] <= bus.rx_data;
            if (accept && (state_q == StCntLo)) count_q[7:0]  <= bus.rx_data;
            // Capture the write so address/data_out keep showing it after WRITE.
            if (in_write) begin
                index_q   <= index_inc;
                address_q <= write_addr;
                data_q    <= word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else if (load) begin
            csum_q <= '0;
        end else if (shift_en) begin
            csum_q <= csum_q + bus.rx_data;
        end
    end

    assign chk_state = (state_q == StChk);
    assign error     = (state_q == StError);
`else
    assign chk_state = 1'b0;
    assign error     = 1'b0;
`endif

    assign bus.rx_ready = (state_q inside {StCntHi, StCntLo, StByte}) || chk_state;
    assign bus.we       = in_write;
    assign bus.address  = in_write ? write_addr : address_q;
    assign bus.data_out = in_write ? word : data_q;

    assign busy     = bus.rx_ready || in_write;
    assign cpu_hold = busy || error;
    assign done     = (state_q == StDone);

endmodule
